// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, FSM states and bit-reverse helper for the 8-point FFT controller
package fft_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FLUSH,
    UNLOAD
  } state_e;

  function automatic logic [ADDR_W-1:0] bitrev3(input logic [ADDR_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// rtl/fft8_addr_gen.sv - combinational butterfly operand addresses and twiddle index for (stage, k)
module fft8_addr_gen
  import fft_pkg::*;
(
  input  logic [1:0]        i_stage,
  input  logic [1:0]        i_k,
  input  logic              i_inverse,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic [2:0]        o_tw_idx
);

  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_pos;
  logic [ADDR_W-1:0] w_grp;
  logic [1:0]        w_tw;

  // pos < span always, so the twiddle exponent fits in two bits at every stage
  always_comb begin
    w_span      = 3'd1 << i_stage;
    w_pos       = {1'b0, i_k} & (w_span - 3'd1);
    w_grp       = {1'b0, i_k} >> i_stage;
    o_rd_addr_a = (w_grp << (i_stage + 2'd1)) | w_pos;
    o_rd_addr_b = o_rd_addr_a + w_span;
    w_tw        = w_pos[1:0] << (2'd2 - i_stage);
    o_tw_idx    = {i_inverse, w_tw};
  end

endmodule

// File: rtl/fft8_controller.sv
// rtl/fft8_controller.sv - load / compute / flush / unload sequencer for the 8-point radix-2 DIT FFT
module fft8_controller
  import fft_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_inverse,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_in_we,
  output logic [ADDR_W-1:0] o_in_addr,
  output logic              o_bf_valid,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic [2:0]        o_tw_idx,
  output logic [1:0]        o_stage,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_wb_addr_a,
  output logic [ADDR_W-1:0] o_wb_addr_b,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]        r_k, w_k_nxt;
  logic [1:0]        r_stage, w_stage_nxt;
  logic [2:0]        r_timer, w_timer_nxt;
  logic              r_inv, w_inv_nxt;
  logic              r_done, w_done_nxt;
  logic              w_bf_valid;

  logic [ADDR_W-1:0] w_ag_a, w_ag_b;
  logic [2:0]        w_ag_tw;

  logic [BF_LAT-1:0]             r_dl_v;
  logic [BF_LAT-1:0][ADDR_W-1:0] r_dl_a;
  logic [BF_LAT-1:0][ADDR_W-1:0] r_dl_b;

  fft8_addr_gen u_addr_gen (
    .i_stage     (r_stage),
    .i_k         (r_k),
    .i_inverse   (r_inv),
    .o_rd_addr_a (w_ag_a),
    .o_rd_addr_b (w_ag_b),
    .o_tw_idx    (w_ag_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_stage <= '0;
      r_timer <= '0;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      r_timer <= w_timer_nxt;
      r_inv   <= w_inv_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_timer_nxt = r_timer;
    w_inv_nxt   = r_inv;
    w_done_nxt  = 1'b0;
    w_bf_valid  = 1'b0;
    o_in_ready  = 1'b0;
    o_in_we     = 1'b0;
    o_in_addr   = '0;
    o_out_valid = 1'b0;
    o_out_addr  = '0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LOAD;
          w_inv_nxt   = i_inverse;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        o_in_ready = 1'b1;
        o_in_addr  = bitrev3(r_cnt);
        if (i_in_valid) begin
          o_in_we   = 1'b1;
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'(N - 1)) begin
            w_state_nxt = COMPUTE;
            w_stage_nxt = '0;
            w_k_nxt     = '0;
            w_cnt_nxt   = '0;
          end
        end
      end
      COMPUTE: begin
        w_bf_valid = 1'b1;
        w_k_nxt    = r_k + 2'd1;
        if (r_k == 2'd3) begin
          w_state_nxt = FLUSH;
          w_timer_nxt = 3'(BF_LAT);
          w_k_nxt     = '0;
        end
      end
      FLUSH: begin
        // wait out the butterfly latency so the next stage reads settled results
        if (r_timer == 3'd1) begin
          if (r_stage == 2'(LOG2N - 1)) begin
            w_state_nxt = UNLOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = COMPUTE;
            w_stage_nxt = r_stage + 2'd1;
            w_k_nxt     = '0;
          end
        end else begin
          w_timer_nxt = r_timer - 3'd1;
        end
      end
      UNLOAD: begin
        o_out_valid = 1'b1;
        o_out_addr  = r_cnt;
        if (i_out_ready) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'(N - 1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_v <= '0;
      r_dl_a <= '0;
      r_dl_b <= '0;
    end else begin
      r_dl_v[0] <= w_bf_valid;
      r_dl_a[0] <= o_rd_addr_a;
      r_dl_b[0] <= o_rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_dl_v[i] <= r_dl_v[i-1];
        r_dl_a[i] <= r_dl_a[i-1];
        r_dl_b[i] <= r_dl_b[i-1];
      end
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_stage     = r_stage;
  assign o_bf_valid  = w_bf_valid;
  assign o_rd_addr_a = w_bf_valid ? w_ag_a  : '0;
  assign o_rd_addr_b = w_bf_valid ? w_ag_b  : '0;
  assign o_tw_idx    = w_bf_valid ? w_ag_tw : '0;
  assign o_wb_en     = r_dl_v[BF_LAT-1];
  assign o_wb_addr_a = r_dl_a[BF_LAT-1];
  assign o_wb_addr_b = r_dl_b[BF_LAT-1];

endmodule

// File: tb/tb_fft8_controller.sv
// tb/tb_fft8_controller.sv - directed table-driven bench for fft8_controller at BF_LAT=2 and BF_LAT=4
module tb_fft8_controller;

  logic clk = 1'b0;
  logic rst_n, start, inverse, in_valid, out_ready;
  always #5 clk = ~clk;

  logic       busy_2, done_2, in_ready_2, in_we_2, bf_valid_2, wb_en_2, out_valid_2;
  logic [2:0] in_addr_2, rd_a_2, rd_b_2, tw_2, wb_a_2, wb_b_2, out_addr_2;
  logic [1:0] stage_2;
  logic       busy_4, done_4, in_ready_4, in_we_4, bf_valid_4, wb_en_4, out_valid_4;
  logic [2:0] in_addr_4, rd_a_4, rd_b_4, tw_4, wb_a_4, wb_b_4, out_addr_4;
  logic [1:0] stage_4;

  fft8_controller #(.BF_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_inverse(inverse),
    .o_busy(busy_2), .o_done(done_2), .i_in_valid(in_valid), .o_in_ready(in_ready_2),
    .o_in_we(in_we_2), .o_in_addr(in_addr_2), .o_bf_valid(bf_valid_2),
    .o_rd_addr_a(rd_a_2), .o_rd_addr_b(rd_b_2), .o_tw_idx(tw_2), .o_stage(stage_2),
    .o_wb_en(wb_en_2), .o_wb_addr_a(wb_a_2), .o_wb_addr_b(wb_b_2),
    .o_out_valid(out_valid_2), .i_out_ready(out_ready), .o_out_addr(out_addr_2)
  );

  fft8_controller #(.BF_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_inverse(inverse),
    .o_busy(busy_4), .o_done(done_4), .i_in_valid(in_valid), .o_in_ready(in_ready_4),
    .o_in_we(in_we_4), .o_in_addr(in_addr_4), .o_bf_valid(bf_valid_4),
    .o_rd_addr_a(rd_a_4), .o_rd_addr_b(rd_b_4), .o_tw_idx(tw_4), .o_stage(stage_4),
    .o_wb_en(wb_en_4), .o_wb_addr_a(wb_a_4), .o_wb_addr_b(wb_b_4),
    .o_out_valid(out_valid_4), .i_out_ready(out_ready), .o_out_addr(out_addr_4)
  );

  logic [29:0] all_2, all_4;
  assign all_2 = {busy_2, done_2, in_ready_2, in_we_2, in_addr_2, bf_valid_2, rd_a_2, rd_b_2,
                  tw_2, stage_2, wb_en_2, wb_a_2, wb_b_2, out_valid_2, out_addr_2};
  assign all_4 = {busy_4, done_4, in_ready_4, in_we_4, in_addr_4, bf_valid_4, rd_a_4, rd_b_4,
                  tw_4, stage_4, wb_en_4, wb_a_4, wb_b_4, out_valid_4, out_addr_4};

  typedef struct {logic [2:0] a; logic [2:0] b; logic [1:0] tw;} bf_vec_t;
  typedef struct {logic v; logic we; logic [2:0] addr;} load_vec_t;
  typedef struct {logic r; logic [2:0] addr;} unl_vec_t;

  bf_vec_t   sched[12];
  load_vec_t lv_fast[8];
  load_vec_t lv_gap[15];
  unl_vec_t  uv_fast[8];
  unl_vec_t  uv_gap[11];
  logic [2:0] order[8];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic exp_inv = 1'b0;

  int         iss_idx[2], last_iss[2], first_iss[2], done_cnt[2], pq_wr[2], pq_rd[2];
  logic       ov_prev[2];
  int         pq_cyc[2][32];
  logic [2:0] pq_a[2][32];
  logic [2:0] pq_b[2][32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic mon_reset();
    for (int d = 0; d < 2; d++) begin
      iss_idx[d] = 0; last_iss[d] = 0; first_iss[d] = 0; done_cnt[d] = 0;
      pq_wr[d] = 0; pq_rd[d] = 0; ov_prev[d] = 1'b0;
    end
  endtask

  task automatic mon(input int d, input logic bfv, input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] tw, input logic wb, input logic [2:0] wa,
                     input logic [2:0] wbb, input logic ov, input logic dn);
    int i, j, l;
    l = lat_of(d);
    if (dn) done_cnt[d]++;
    if (bfv) begin
      i = iss_idx[d];
      if (i < 12) begin
        chk($sformatf("bf_addr_a d%0d i%0d", d, i), a, sched[i].a);
        chk($sformatf("bf_addr_b d%0d i%0d", d, i), b, sched[i].b);
        chk($sformatf("bf_tw d%0d i%0d", d, i), tw, {exp_inv, sched[i].tw});
      end else begin
        chk($sformatf("bf_extra_issue d%0d", d), i, 11);
      end
      if (i == 0) first_iss[d] = cyc;
      else chk($sformatf("bf_gap d%0d i%0d", d, i), cyc - last_iss[d], (i % 4 == 0) ? l + 1 : 1);
      last_iss[d] = cyc;
      j = pq_wr[d] % 32;
      pq_cyc[d][j] = cyc + l; pq_a[d][j] = a; pq_b[d][j] = b;
      pq_wr[d]++;
      iss_idx[d] = i + 1;
    end
    if (wb) begin
      if (pq_wr[d] == pq_rd[d]) begin
        chk($sformatf("wb_spurious d%0d", d), 1, 0);
      end else begin
        j = pq_rd[d] % 32;
        chk($sformatf("wb_latency d%0d", d), cyc, pq_cyc[d][j]);
        chk($sformatf("wb_addr_a d%0d", d), wa, pq_a[d][j]);
        chk($sformatf("wb_addr_b d%0d", d), wbb, pq_b[d][j]);
        pq_rd[d]++;
      end
    end
    if (ov && !ov_prev[d]) chk($sformatf("compute_len d%0d", d), cyc - first_iss[d], 3 * (4 + l));
    ov_prev[d] = ov;
  endtask

  always @(negedge clk) if (rst_n === 1'b1)
    mon(0, bf_valid_2, rd_a_2, rd_b_2, tw_2, wb_en_2, wb_a_2, wb_b_2, out_valid_2, done_2);
  always @(negedge clk) if (rst_n === 1'b1)
    mon(1, bf_valid_4, rd_a_4, rd_b_4, tw_4, wb_en_4, wb_a_4, wb_b_4, out_valid_4, done_4);

  task automatic do_load(input logic inv, input logic gap);
    int n;
    @(negedge clk);
    start = 1'b1; inverse = inv;
    @(negedge clk);
    start = 1'b0; inverse = ~inv;
    n = gap ? 15 : 8;
    for (int i = 0; i < n; i++) begin
      in_valid = gap ? lv_gap[i].v : lv_fast[i].v;
      #1;
      chk($sformatf("in_ready v%0d", i), in_ready_2, 1);
      chk($sformatf("in_we v%0d", i), in_we_2, gap ? lv_gap[i].we : lv_fast[i].we);
      chk($sformatf("in_addr v%0d", i), in_addr_2, gap ? lv_gap[i].addr : lv_fast[i].addr);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("in_ready_drop", in_ready_2, 0);
  endtask

  task automatic do_unload(input logic gap, input logic pulse_start);
    int t, n;
    t = 0;
    out_ready = 1'b0;
    while (!out_valid_2 && t < 200) begin
      start = (pulse_start && t == 3);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("unload_reached", out_valid_2, 1);
    if (!out_valid_2) return;
    n = gap ? 11 : 8;
    for (int i = 0; i < n; i++) begin
      out_ready = gap ? uv_gap[i].r : uv_fast[i].r;
      #1;
      chk($sformatf("out_valid u%0d", i), out_valid_2, 1);
      chk($sformatf("out_addr u%0d", i), out_addr_2, gap ? uv_gap[i].addr : uv_fast[i].addr);
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    chk("done_pulse", done_2, 1);
    chk("busy_at_done", busy_2, 0);
    chk("out_valid_at_done", out_valid_2, 0);
    @(negedge clk);
    #1;
    chk("done_clears", done_2, 0);
  endtask

  task automatic finish_xfer();
    int t;
    out_ready = 1'b1;
    t = 0;
    while ((busy_2 || busy_4) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("both_idle", (busy_2 || busy_4) ? 1 : 0, 0);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("issue_count d%0d", d), iss_idx[d], 12);
      chk($sformatf("wb_pending d%0d", d), pq_wr[d] - pq_rd[d], 0);
      chk($sformatf("done_count d%0d", d), done_cnt[d], 1);
    end
    out_ready = 1'b0;
    mon_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; inverse = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    order = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    sched[0]  = '{3'd0, 3'd1, 2'd0}; sched[1]  = '{3'd2, 3'd3, 2'd0};
    sched[2]  = '{3'd4, 3'd5, 2'd0}; sched[3]  = '{3'd6, 3'd7, 2'd0};
    sched[4]  = '{3'd0, 3'd2, 2'd0}; sched[5]  = '{3'd1, 3'd3, 2'd2};
    sched[6]  = '{3'd4, 3'd6, 2'd0}; sched[7]  = '{3'd5, 3'd7, 2'd2};
    sched[8]  = '{3'd0, 3'd4, 2'd0}; sched[9]  = '{3'd1, 3'd5, 2'd1};
    sched[10] = '{3'd2, 3'd6, 2'd2}; sched[11] = '{3'd3, 3'd7, 2'd3};
    for (int i = 0; i < 8; i++) lv_fast[i] = '{1'b1, 1'b1, order[i]};
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) lv_gap[i] = '{1'b1, 1'b1, order[i/2]};
      else            lv_gap[i] = '{1'b0, 1'b0, order[(i+1)/2]};
    end
    for (int i = 0; i < 8; i++) uv_fast[i] = '{1'b1, 3'(i)};
    uv_gap[0] = '{1'b1, 3'd0}; uv_gap[1] = '{1'b1, 3'd1}; uv_gap[2] = '{1'b1, 3'd2};
    uv_gap[3] = '{1'b0, 3'd3}; uv_gap[4] = '{1'b0, 3'd3}; uv_gap[5] = '{1'b0, 3'd3};
    for (int i = 6; i < 11; i++) uv_gap[i] = '{1'b1, 3'(i - 3)};
    mon_reset();

    repeat (3) @(negedge clk);
    chk("reset_outputs dut2", all_2, 0);
    chk("reset_outputs dut4", all_4, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy_2, busy_4, in_ready_2}, 0);

    // forward transform, back-to-back handshakes, start pulsed while computing
    exp_inv = 1'b0;
    do_load(1'b0, 1'b0);
    do_unload(1'b0, 1'b1);
    finish_xfer();

    // inverse transform with in_valid gaps and a held-off unload
    exp_inv = 1'b1;
    do_load(1'b1, 1'b1);
    do_unload(1'b1, 1'b0);
    finish_xfer();

    // abort with reset at stage 1, k=2 while issues are still in flight
    exp_inv = 1'b0;
    do_load(1'b0, 1'b0);
    t = 0;
    while (!(bf_valid_2 && stage_2 == 2'd1 && rd_a_2 == 3'd4) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reached_stage1_k2", t < 100 ? 1 : 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs dut2", all_2, 0);
    chk("abort_outputs dut4", all_4, 0);
    mon_reset();
    @(negedge clk);
    @(negedge clk);
    chk("held_reset dut2", all_2, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_abort_quiet c%0d", i), {wb_en_2, wb_en_4, done_2, done_4, busy_2, busy_4}, 0);
    end

    exp_inv = 1'b0;
    do_load(1'b0, 1'b0);
    do_unload(1'b0, 1'b0);
    finish_xfer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
